// File: rtl/drlp_cfg_loader_if.sv
// Loader-side bundle: start request, descriptor-memory read port, config-bank write port and status.
interface drlp_cfg_loader_if;
  logic        i_go;
  logic [15:0] i_base_addr;
  logic [7:0]  i_num_layers;
  logic        o_mem_rd_en;
  logic [15:0] o_mem_addr;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_rd_valid;
  logic [31:0] o_cfg;
  logic [2:0]  o_cfg_addr;
  logic        o_cfg_wr_en;
  logic        i_layer_done;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_layer_idx;
  logic        o_timeout;

  modport master (
    input  i_go, i_base_addr, i_num_layers, i_mem_rd_data, i_mem_rd_valid, i_layer_done,
    output o_mem_rd_en, o_mem_addr, o_cfg, o_cfg_addr, o_cfg_wr_en, o_busy, o_done,
    output o_layer_idx, o_timeout
  );

  modport slave (
    output i_go, i_base_addr, i_num_layers, i_mem_rd_data, i_mem_rd_valid, i_layer_done,
    input  o_mem_rd_en, o_mem_addr, o_cfg, o_cfg_addr, o_cfg_wr_en, o_busy, o_done,
    input  o_layer_idx, o_timeout
  );
endinterface

// File: rtl/drlp_cfg_loader.sv
// Layer-program loader: copies 6 descriptor words per layer into cfg 0..5, then sets/clears cfg 6 around the run.
// Optional RUN watchdog built in when DRLP_CFG_LOADER_TIMEOUT_EN is defined; otherwise RUN waits forever.
module drlp_cfg_loader (
  input  logic              i_clk,
  input  logic              i_rst_n,
  drlp_cfg_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAITRD = 3'd2,
    WRITE  = 3'd3,
    START  = 3'd4,
    RUN    = 3'd5,
    CLEAR  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] rd_addr, rd_addr_nxt;
  logic [2:0]  word, word_nxt;
  logic [7:0]  layer, layer_nxt;
  logic [7:0]  last_layer, last_layer_nxt;
  logic [31:0] rd_word, rd_word_nxt;
  logic        zero_done, zero_done_nxt;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
  logic [15:0] wdog, wdog_nxt;
  logic        timed_out, timed_out_nxt;
  logic        timeout;
`endif

  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        cfg_wr_en;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg;
  logic        prog_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rd_addr    <= 16'd0;
      word       <= 3'd0;
      layer      <= 8'd0;
      last_layer <= 8'd0;
      rd_word    <= 32'd0;
      zero_done  <= 1'b0;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
      wdog       <= 16'd0;
      timed_out  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      rd_addr    <= rd_addr_nxt;
      word       <= word_nxt;
      layer      <= layer_nxt;
      last_layer <= last_layer_nxt;
      rd_word    <= rd_word_nxt;
      zero_done  <= zero_done_nxt;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
      wdog       <= wdog_nxt;
      timed_out  <= timed_out_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    rd_addr_nxt    = rd_addr;
    word_nxt       = word;
    layer_nxt      = layer;
    last_layer_nxt = last_layer;
    rd_word_nxt    = rd_word;
    zero_done_nxt  = 1'b0;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
    wdog_nxt       = wdog;
    timed_out_nxt  = timed_out;
    timeout        = 1'b0;
`endif
    mem_rd_en      = 1'b0;
    mem_addr       = 16'd0;
    cfg_wr_en      = 1'b0;
    cfg_addr       = 3'd0;
    cfg            = 32'd0;
    prog_done      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_go) begin
          if (bus.i_num_layers != 8'd0) begin
            state_nxt      = FETCH;
            rd_addr_nxt    = bus.i_base_addr;
            word_nxt       = 3'd0;
            layer_nxt      = 8'd0;
            last_layer_nxt = bus.i_num_layers - 8'd1;
          end else begin
            // Empty program completes on the following cycle without touching memory or cfg.
            zero_done_nxt = 1'b1;
          end
        end
      end

      FETCH: begin
        mem_rd_en   = 1'b1;
        mem_addr    = rd_addr;
        // Descriptors are contiguous across layers, so one wrapping pointer covers base + 6n + k.
        rd_addr_nxt = rd_addr + 16'd1;
        state_nxt   = WAITRD;
      end

      WAITRD: begin
        if (bus.i_mem_rd_valid) begin
          rd_word_nxt = bus.i_mem_rd_data;
          state_nxt   = WRITE;
        end
      end

      WRITE: begin
        cfg_wr_en = 1'b1;
        cfg_addr  = word;
        cfg       = rd_word;
        if (word == 3'd5) begin
          word_nxt  = 3'd0;
          state_nxt = START;
        end else begin
          word_nxt  = word + 3'd1;
          state_nxt = FETCH;
        end
      end

      START: begin
        cfg_wr_en = 1'b1;
        cfg_addr  = 3'd6;
        cfg       = 32'h1;
        state_nxt = RUN;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
        wdog_nxt  = 16'd0;
`endif
      end

      RUN: begin
        if (bus.i_layer_done) begin
          state_nxt = CLEAR;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
        end else if (wdog == 16'hFFFE) begin
          // This is the 65535th RUN cycle with no completion.
          timed_out_nxt = 1'b1;
          state_nxt     = CLEAR;
        end else begin
          wdog_nxt = wdog + 16'd1;
`endif
        end
      end

      CLEAR: begin
        cfg_wr_en = 1'b1;
        cfg_addr  = 3'd6;
        cfg       = 32'h0;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
        if (timed_out) begin
          timeout       = 1'b1;
          timed_out_nxt = 1'b0;
          layer_nxt     = 8'd0;
          state_nxt     = IDLE;
        end else
`endif
        if (layer == last_layer) begin
          prog_done = 1'b1;
          layer_nxt = 8'd0;
          state_nxt = IDLE;
        end else begin
          layer_nxt = layer + 8'd1;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_mem_rd_en = mem_rd_en;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_cfg_wr_en = cfg_wr_en;
  assign bus.o_cfg_addr  = cfg_addr;
  assign bus.o_cfg       = cfg;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = zero_done | prog_done;
  assign bus.o_layer_idx = layer;
`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
  assign bus.o_timeout   = timeout;
`else
  assign bus.o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_drlp_cfg_loader.sv
// Bench for drlp_cfg_loader: vector table of programs checked through read/write scoreboards plus reset and watchdog sequences.
module tb_drlp_cfg_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drlp_cfg_loader_if bus ();
  drlp_cfg_loader dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  idx;
  } rd_exp_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] dat;
    logic [7:0]  idx;
  } wr_exp_t;

  typedef struct {
    logic [15:0] base;
    int          layers;
    int          lat;
    int          ld_dly;
    bit          disturb;
    int          exp_reads;
    int          exp_writes;
    int          exp_start;
    int          exp_done;
  } vec_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      start_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int to_cnt   = 0;
  int to_cyc   = 0;
  bit to_wr    = 1'b0;

  int mem_lat = 1;
  int ld_dly  = 0;
  bit ld_auto = 1'b0;
  int vld_req = 0, vld_ack = 0;
  int ld_req  = 0, ld_ack  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every read and cfg write must match the head of its queue.
  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    if (rst_n) begin
      if (bus.o_mem_rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: read of %04h with none expected", bus.o_mem_addr);
        end else begin
          re = rd_q.pop_front();
          check("rd_addr", 64'(bus.o_mem_addr), 64'(re.addr));
          check("rd_layer_idx", 64'(bus.o_layer_idx), 64'(re.idx));
          check("rd_busy", 64'(bus.o_busy), 64'd1);
        end
      end
      if (bus.o_cfg_wr_en) begin
        wr_cnt++;
        if (bus.o_cfg_addr == 3'd6 && bus.o_cfg == 32'h1) start_q.push_back(cyc);
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: write (%0d,%08h) with none expected", bus.o_cfg_addr, bus.o_cfg);
        end else begin
          we = wr_q.pop_front();
          check("wr_addr", 64'(bus.o_cfg_addr), 64'(we.addr));
          check("wr_data", 64'(bus.o_cfg), 64'(we.dat));
          check("wr_layer_idx", 64'(bus.o_layer_idx), 64'(we.idx));
        end
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.o_timeout) begin
        to_cnt++;
        to_cyc = cyc;
        to_wr  = bus.o_cfg_wr_en && bus.o_cfg_addr == 3'd6 && bus.o_cfg == 32'h0;
      end
    end
  end

  // Descriptor memory: returns data = word address mem_lat cycles after each read request.
  always @(negedge clk) begin : mem_model
    static int       dn = 0;
    static logic [15:0] pend = 16'h0;
    bus.i_mem_rd_valid = 1'b0;
    if (vld_req != vld_ack) begin
      bus.i_mem_rd_valid = 1'b1;
      bus.i_mem_rd_data  = 32'hDEAD_BEEF;
      vld_ack            = vld_req;
    end
    if (dn > 0) begin
      dn--;
      if (dn == 0) begin
        bus.i_mem_rd_valid = 1'b1;
        bus.i_mem_rd_data  = {16'h0, pend};
      end
    end
    if (bus.o_mem_rd_en) begin
      pend = bus.o_mem_addr;
      dn   = mem_lat;
    end
  end

  // Datapath: pulses layer_done ld_dly cycles into RUN, plus any stray pulses requested by the test.
  always @(negedge clk) begin : ld_model
    static int dn = 0;
    bus.i_layer_done = 1'b0;
    if (ld_req != ld_ack) begin
      bus.i_layer_done = 1'b1;
      ld_ack           = ld_req;
    end
    if (dn > 0) begin
      dn--;
      if (dn == 0) bus.i_layer_done = 1'b1;
    end
    if (ld_auto && bus.o_cfg_wr_en && bus.o_cfg_addr == 3'd6 && bus.o_cfg == 32'h1) dn = ld_dly + 1;
  end

  task automatic push_layer(input logic [15:0] base, input int n, input bit with_clear);
    logic [15:0] a;
    for (int k = 0; k < 6; k++) begin
      a = base + 16'(6 * n + k);
      rd_q.push_back('{addr: a, idx: 8'(n)});
      wr_q.push_back('{addr: 3'(k), dat: {16'h0, a}, idx: 8'(n)});
    end
    wr_q.push_back('{addr: 3'd6, dat: 32'h1, idx: 8'(n)});
    if (with_clear) wr_q.push_back('{addr: 3'd6, dat: 32'h0, idx: 8'(n)});
  endtask

  task automatic pulse_go(input logic [15:0] base, input int layers, output int go_c);
    @(posedge clk);
    #1;
    bus.i_go         = 1'b1;
    bus.i_base_addr  = base;
    bus.i_num_layers = 8'(layers);
    go_c             = cyc;
    @(posedge clk);
    #1;
    bus.i_go         = 1'b0;
    bus.i_base_addr  = 16'($urandom);
    bus.i_num_layers = 8'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int rd0, wr0, st0, dn0, go_c, t;
    mem_lat = v.lat;
    ld_dly  = v.ld_dly;
    ld_auto = 1'b1;
    for (int n = 0; n < v.layers; n++) push_layer(v.base, n, 1'b1);
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_q.size(); dn0 = done_cnt;
    if (v.disturb) begin
      // Stray read-valid and layer_done while IDLE.
      @(posedge clk); #1;
      vld_req++;
      ld_req++;
      repeat (3) @(posedge clk);
      #1;
    end
    pulse_go(v.base, v.layers, go_c);
    if (v.disturb) begin
      t = 0;
      while (rd_cnt == rd0 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      // Now in the first WAITRD cycle: a competing go and a stray layer_done.
      bus.i_go         = 1'b1;
      bus.i_base_addr  = 16'h9999;
      bus.i_num_layers = 8'd5;
      ld_req++;
      @(posedge clk); #1;
      bus.i_go = 1'b0;
    end
    t = 0;
    while (done_cnt == dn0 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    check("done_seen", 64'(done_cnt - dn0), 64'd1);
    check("done_latency", 64'(done_cyc - go_c), 64'(v.exp_done));
    if (v.layers != 0 && start_q.size() > st0)
      check("start_latency", 64'(start_q[st0] - go_c), 64'(v.exp_start));
    repeat (3) @(posedge clk);
    #1;
    check("read_count", 64'(rd_cnt - rd0), 64'(v.exp_reads));
    check("write_count", 64'(wr_cnt - wr0), 64'(v.exp_writes));
    check("single_done", 64'(done_cnt - dn0), 64'd1);
    check("idle_busy", 64'(bus.o_busy), 64'd0);
    check("idle_layer_idx", 64'(bus.o_layer_idx), 64'd0);
    check("sb_drained", 64'(rd_q.size() + wr_q.size()), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int go_c, wr0, rd0, st0, dn0, t;
    vecs[0] = '{16'h0010, 1, 1, 3, 1'b0,  6,  8, 19,  24};
    vecs[1] = '{16'hFFFC, 2, 1, 3, 1'b0, 12, 16, 19,  48};
    vecs[2] = '{16'h0100, 0, 1, 0, 1'b0,  0,  0,  0,   1};
    vecs[3] = '{16'h1234, 1, 2, 0, 1'b0,  6,  8, 25,  27};
    vecs[4] = '{16'h00F0, 3, 3, 1, 1'b0, 18, 24, 31, 102};
    vecs[5] = '{16'h0040, 1, 4, 2, 1'b1,  6,  8, 37,  41};

    bus.i_go         = 1'b0;
    bus.i_base_addr  = 16'h0;
    bus.i_num_layers = 8'h0;
    rst_n            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_rd_en", 64'(bus.o_mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(bus.o_cfg_wr_en), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_timeout", 64'(bus.o_timeout), 64'd0);
    check("rst_cfg", 64'({bus.o_cfg, bus.o_cfg_addr}), 64'd0);
    check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    check("rst_layer_idx", 64'(bus.o_layer_idx), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during RUN abandons the program: no cfg6=0 write afterwards.
    ld_auto = 1'b0;
    mem_lat = 1;
    push_layer(16'h0200, 0, 1'b0);
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_q.size(); dn0 = done_cnt;
    pulse_go(16'h0200, 1, go_c);
    t = 0;
    while (start_q.size() == st0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("rstrun_started", 64'(start_q.size() - st0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("rstrun_busy_before", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstrun_busy", 64'(bus.o_busy), 64'd0);
    check("rstrun_strobes", 64'({bus.o_mem_rd_en, bus.o_cfg_wr_en, bus.o_done, bus.o_timeout}), 64'd0);
    check("rstrun_cfg", 64'({bus.o_cfg, bus.o_cfg_addr}), 64'd0);
    check("rstrun_addr_idx", 64'({bus.o_mem_addr, bus.o_layer_idx}), 64'd0);
    rst_n = 1'b1;
    ld_req++;
    repeat (20) @(posedge clk);
    #1;
    check("rstrun_writes", 64'(wr_cnt - wr0), 64'd7);
    check("rstrun_reads", 64'(rd_cnt - rd0), 64'd6);
    check("rstrun_no_done", 64'(done_cnt - dn0), 64'd0);
    check("rstrun_idle", 64'(bus.o_busy), 64'd0);
    check("rstrun_sb", 64'(rd_q.size() + wr_q.size()), 64'd0);

    run_vec(vecs[0]);

`ifdef DRLP_CFG_LOADER_TIMEOUT_EN
    // Watchdog: two layers requested, first never completes.
    ld_auto = 1'b0;
    push_layer(16'h0300, 0, 1'b1);
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_q.size(); dn0 = done_cnt;
    pulse_go(16'h0300, 2, go_c);
    t = 0;
    while (to_cnt == 0 && t < 70000) begin
      @(posedge clk); #1; t++;
    end
    check("wd_fired", 64'(to_cnt), 64'd1);
    if (start_q.size() > st0) check("wd_run_cycles", 64'(to_cyc - start_q[st0]), 64'd65536);
    check("wd_clear_write", 64'(to_wr), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("wd_no_done", 64'(done_cnt - dn0), 64'd0);
    check("wd_idle", 64'(bus.o_busy), 64'd0);
    check("wd_reads", 64'(rd_cnt - rd0), 64'd6);
    check("wd_writes", 64'(wr_cnt - wr0), 64'd8);
    check("wd_single_pulse", 64'(to_cnt), 64'd1);
`else
    check("no_timeout", 64'(to_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
